// File: rtl/arc4_prga.sv
// ARC4 keystream generator: reads length and ciphertext, updates the S-box, writes plaintext.
// Latency: 4 cycles of setup plus 10 cycles per byte from accepting i_en back to idle.
// Backpressure: none; o_rdy is high only when idle, and i_en is ignored while busy.
module arc4_prga (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic       o_rdy,
    output logic [7:0] o_s_addr,
    input  logic [7:0] i_s_rddata,
    output logic [7:0] o_s_wrdata,
    output logic       o_s_wren,
    output logic [7:0] o_ct_addr,
    input  logic [7:0] i_ct_rddata,
    output logic [7:0] o_pt_addr,
    output logic [7:0] o_pt_wrdata,
    output logic       o_pt_wren
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_LEN = 4'd1,
        WT_LEN = 4'd2,
        WR_LEN = 4'd3,
        RD_SI  = 4'd4,
        WT_SI  = 4'd5,
        RD_SJ  = 4'd6,
        WT_SJ  = 4'd7,
        WR_SI  = 4'd8,
        WR_SJ  = 4'd9,
        RD_PAD = 4'd10,
        WT_PAD = 4'd11,
        WR_PT  = 4'd12
    } state_t;

    state_t     r_state;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_k;
    logic [7:0] r_len;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] r_ctk;
    logic       r_wt2;
    logic [7:0] r_s_addr;
    logic [7:0] r_s_wrdata;
    logic       r_s_wren;
    logic [7:0] r_ct_addr;
    logic [7:0] r_pt_addr;
    logic [7:0] r_pt_wrdata;
    logic       r_pt_wren;

    state_t     w_state;
    logic [7:0] w_i;
    logic [7:0] w_j;
    logic [7:0] w_k;
    logic [7:0] w_len;
    logic [7:0] w_si;
    logic [7:0] w_sj;
    logic [7:0] w_ctk;
    logic       w_wt2;
    logic [7:0] w_s_addr;
    logic [7:0] w_s_wrdata;
    logic       w_s_wren;
    logic [7:0] w_ct_addr;
    logic [7:0] w_pt_addr;
    logic [7:0] w_pt_wrdata;
    logic       w_pt_wren;
    logic [7:0] w_j_sum;
    logic [7:0] w_pad_idx;

    assign w_j_sum   = r_j + i_s_rddata;
    assign w_pad_idx = r_si + r_sj;

    // Next-state and next-output decode; write enables default low so they pulse for one cycle.
    always_comb begin
        w_state     = r_state;
        w_i         = r_i;
        w_j         = r_j;
        w_k         = r_k;
        w_len       = r_len;
        w_si        = r_si;
        w_sj        = r_sj;
        w_ctk       = r_ctk;
        w_wt2       = r_wt2;
        w_s_addr    = r_s_addr;
        w_s_wrdata  = r_s_wrdata;
        w_s_wren    = 1'b0;
        w_ct_addr   = r_ct_addr;
        w_pt_addr   = r_pt_addr;
        w_pt_wrdata = r_pt_wrdata;
        w_pt_wren   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_en) begin
                    w_i       = 8'd0;
                    w_j       = 8'd0;
                    w_k       = 8'd0;
                    w_ct_addr = 8'd0;
                    w_state   = RD_LEN;
                end
            end
            RD_LEN: w_state = WT_LEN;
            WT_LEN: begin
                w_len       = i_ct_rddata;
                w_pt_addr   = 8'd0;
                w_pt_wrdata = i_ct_rddata;
                w_pt_wren   = 1'b1;
                w_state     = WR_LEN;
            end
            WR_LEN: begin
                if (r_len == 8'd0) begin
                    w_state = IDLE;
                end else begin
                    w_k       = 8'd1;
                    w_i       = 8'd1;
                    w_s_addr  = 8'd1;
                    w_ct_addr = 8'd1;
                    w_state   = RD_SI;
                end
            end
            RD_SI: w_state = WT_SI;
            WT_SI: begin
                // j is advanced and its S-box read is issued straight from the returning S[i]
                w_si     = i_s_rddata;
                w_j      = w_j_sum;
                w_s_addr = w_j_sum;
                w_state  = RD_SJ;
            end
            RD_SJ: w_state = WT_SJ;
            WT_SJ: begin
                w_sj       = i_s_rddata;
                w_ctk      = i_ct_rddata;
                w_s_wren   = 1'b1;
                w_s_addr   = r_i;
                w_s_wrdata = i_s_rddata;
                w_state    = WR_SI;
            end
            WR_SI: begin
                w_s_wren   = 1'b1;
                w_s_addr   = r_j;
                w_s_wrdata = r_si;
                w_state    = WR_SJ;
            end
            WR_SJ: w_state = RD_PAD;
            RD_PAD: begin
                // pad address is issued here, so its data needs two wait cycles in WT_PAD
                w_s_addr = w_pad_idx;
                w_wt2    = 1'b0;
                w_state  = WT_PAD;
            end
            WT_PAD: begin
                if (!r_wt2) begin
                    w_wt2 = 1'b1;
                end else begin
                    w_pt_wren   = 1'b1;
                    w_pt_addr   = r_k;
                    w_pt_wrdata = i_s_rddata ^ r_ctk;
                    w_state     = WR_PT;
                end
            end
            WR_PT: begin
                // compare before incrementing so k and i never wrap when L is 255
                if (r_k == r_len) begin
                    w_state = IDLE;
                end else begin
                    w_k       = r_k + 8'd1;
                    w_i       = r_i + 8'd1;
                    w_s_addr  = r_i + 8'd1;
                    w_ct_addr = r_k + 8'd1;
                    w_state   = RD_SI;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset returns everything to idle zeros.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_i         <= 8'd0;
            r_j         <= 8'd0;
            r_k         <= 8'd0;
            r_len       <= 8'd0;
            r_si        <= 8'd0;
            r_sj        <= 8'd0;
            r_ctk       <= 8'd0;
            r_wt2       <= 1'b0;
            r_s_addr    <= 8'd0;
            r_s_wrdata  <= 8'd0;
            r_s_wren    <= 1'b0;
            r_ct_addr   <= 8'd0;
            r_pt_addr   <= 8'd0;
            r_pt_wrdata <= 8'd0;
            r_pt_wren   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_i         <= w_i;
            r_j         <= w_j;
            r_k         <= w_k;
            r_len       <= w_len;
            r_si        <= w_si;
            r_sj        <= w_sj;
            r_ctk       <= w_ctk;
            r_wt2       <= w_wt2;
            r_s_addr    <= w_s_addr;
            r_s_wrdata  <= w_s_wrdata;
            r_s_wren    <= w_s_wren;
            r_ct_addr   <= w_ct_addr;
            r_pt_addr   <= w_pt_addr;
            r_pt_wrdata <= w_pt_wrdata;
            r_pt_wren   <= w_pt_wren;
        end
    end

    assign o_rdy       = (r_state == IDLE);
    assign o_s_addr    = r_s_addr;
    assign o_s_wrdata  = r_s_wrdata;
    assign o_s_wren    = r_s_wren;
    assign o_ct_addr   = r_ct_addr;
    assign o_pt_addr   = r_pt_addr;
    assign o_pt_wrdata = r_pt_wrdata;
    assign o_pt_wren   = r_pt_wren;

endmodule

// File: tb/tb_arc4_prga.sv
// Bench for arc4_prga: synchronous-read memories around the DUT and a software ARC4 reference.
// Latency: checks total run length of 4 + 10*L cycles per run.
// Backpressure: exercises ignored i_en while busy, reset mid-run and reset-over-enable priority.
module tb_arc4_prga;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rd;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rd;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    logic       ld_en;
    logic [7:0] ld_a;
    logic [7:0] ld_s;
    logic [7:0] ld_ct;

    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_img  [256];
    logic [7:0] ct_img [256];
    logic [7:0] m_s    [256];
    logic [7:0] exp_pt [256];
    logic [15:0] exp_q [$];
    logic [15:0] e;

    int checks = 0;
    int errors = 0;

    arc4_prga dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .o_rdy       (rdy),
        .o_s_addr    (s_addr),
        .i_s_rddata  (s_rd),
        .o_s_wrdata  (s_wrdata),
        .o_s_wren    (s_wren),
        .o_ct_addr   (ct_addr),
        .i_ct_rddata (ct_rd),
        .o_pt_addr   (pt_addr),
        .o_pt_wrdata (pt_wrdata),
        .o_pt_wren   (pt_wren)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories; the bench preloads them through ld_* while the DUT is idle.
    always @(posedge clk) begin
        if (ld_en) begin
            s_mem[ld_a]  <= ld_s;
            ct_mem[ld_a] <= ld_ct;
            pt_mem[ld_a] <= 8'hEE;
        end else begin
            if (s_wren)  s_mem[s_addr]   <= s_wrdata;
            if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
        end
        s_rd  <= s_mem[s_addr];
        ct_rd <= ct_mem[ct_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Every cycle: write enables exclusive; each plaintext write must match the next reference byte.
    always @(negedge clk) begin
        if (!rst) begin
            chk("wren_exclusive", {31'd0, s_wren & pt_wren}, 32'd0);
            if (pt_wren) begin
                chk("pt_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pt_addr", {24'd0, pt_addr}, {24'd0, e[15:8]});
                    chk("pt_data", {24'd0, pt_wrdata}, {24'd0, e[7:0]});
                end
            end
        end
    end

    // Software ARC4 over the bench's own S and ct images.
    task automatic model_run();
        logic [7:0] i, j, t, idx;
        int L;
        for (int a = 0; a < 256; a++) m_s[a] = s_img[a];
        L = int'(ct_img[0]);
        exp_pt[0] = ct_img[0];
        exp_q.push_back({8'd0, ct_img[0]});
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= L; k++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i];
            m_s[i] = m_s[j];
            m_s[j] = t;
            idx = m_s[i] + m_s[j];
            exp_pt[k] = m_s[idx] ^ ct_img[k];
            exp_q.push_back({8'(k), exp_pt[k]});
        end
    endtask

    task automatic ksa_key();
        logic [7:0] key [3];
        logic [7:0] j, t;
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            j = j + s_img[a] + key[a % 3];
            t = s_img[a];
            s_img[a] = s_img[j];
            s_img[j] = t;
        end
    endtask

    task automatic identity_s();
        for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
    endtask

    task automatic clear_ct();
        for (int a = 0; a < 256; a++) ct_img[a] = 8'd0;
    endtask

    task automatic load_mems();
        for (int a = 0; a < 256; a++) begin
            ld_en = 1'b1;
            ld_a  = 8'(a);
            ld_s  = s_img[a];
            ld_ct = ct_img[a];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic run_prga(input bit pulse);
        int L, n, sc, total, bad;
        load_mems();
        model_run();
        L = int'(ct_img[0]);
        total = 4 + 10 * L;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        n = 1;
        sc = 0;
        while (!rdy && n < 6000) begin
            if (s_wren) sc++;
            en = pulse && (n < total - 2) && (n % 3 == 0);
            @(posedge clk); #1;
            n++;
        end
        en = 1'b0;
        chk("cycles", n, total);
        chk("s_wren_count", sc, 2 * L);
        chk("pt_all_written", exp_q.size(), 0);
        exp_q.delete();
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad++;
        chk("s_final", bad, 0);
        bad = 0;
        for (int a = 0; a <= L; a++) if (pt_mem[a] !== exp_pt[a]) bad++;
        chk("pt_mem", bad, 0);
    endtask

    initial begin
        int sc, n;
        rst = 1'b1; en = 1'b0; ld_en = 1'b0; ld_a = 8'd0; ld_s = 8'd0; ld_ct = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("rst_pt_wren", {31'd0, pt_wren}, 32'd0);
        chk("rst_addrs", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
        rst = 1'b0;

        // L = 0: only pt[0] is written, no S-box traffic
        identity_s(); clear_ct();
        run_prga(1'b0);
        chk("l0_pt0", {24'd0, pt_mem[0]}, 32'h00);

        // L = 1 with i == j on the only byte
        identity_s(); clear_ct(); ct_img[0] = 8'd1;
        run_prga(1'b0);
        chk("l1_pt0", {24'd0, pt_mem[0]}, 32'h01);
        chk("l1_pt1", {24'd0, pt_mem[1]}, 32'h02);
        chk("l1_s1", {24'd0, s_mem[1]}, 32'h01);

        // L = 2: second byte swaps S[2] and S[3]
        identity_s(); clear_ct(); ct_img[0] = 8'd2; ct_img[2] = 8'hFF;
        run_prga(1'b0);
        chk("l2_pt1", {24'd0, pt_mem[1]}, 32'h02);
        chk("l2_pt2", {24'd0, pt_mem[2]}, 32'hFA);
        chk("l2_s2", {24'd0, s_mem[2]}, 32'h03);
        chk("l2_s3", {24'd0, s_mem[3]}, 32'h02);

        // L = 255 with key "Key": first bytes decrypt "Plai" to the published ciphertext
        ksa_key(); clear_ct(); ct_img[0] = 8'd255;
        for (int a = 1; a < 256; a++) ct_img[a] = 8'($urandom_range(0, 255));
        ct_img[1] = 8'h50; ct_img[2] = 8'h6C; ct_img[3] = 8'h61; ct_img[4] = 8'h69;
        run_prga(1'b0);
        chk("key_pt1", {24'd0, pt_mem[1]}, 32'hBB);
        chk("key_pt2", {24'd0, pt_mem[2]}, 32'hF3);
        chk("key_pt3", {24'd0, pt_mem[3]}, 32'h16);
        chk("key_pt4", {24'd0, pt_mem[4]}, 32'hE8);

        // en pulsed while busy must not disturb the run
        ksa_key(); clear_ct(); ct_img[0] = 8'd20;
        for (int a = 1; a <= 20; a++) ct_img[a] = 8'($urandom_range(0, 255));
        run_prga(1'b1);

        // reset during WR_SI of byte 3, then a clean restart
        identity_s(); clear_ct(); ct_img[0] = 8'd6;
        for (int a = 1; a <= 6; a++) ct_img[a] = 8'(a);
        load_mems();
        model_run();
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        sc = 0; n = 0;
        while (sc < 5 && n < 200) begin
            if (s_wren) sc++;
            if (sc < 5) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("mid_reach_wr_si3", sc, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rdy", {31'd0, rdy}, 32'd1);
        chk("mid_rst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("mid_rst_pt_wren", {31'd0, pt_wren}, 32'd0);
        chk("mid_rst_addrs", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
        chk("mid_rst_wrdata", {16'd0, s_wrdata, pt_wrdata}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        run_prga(1'b0);
        chk("restart_pt0", {24'd0, pt_mem[0]}, 32'h06);

        // reset wins over en in the same cycle
        rst = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        chk("prio_rdy", {31'd0, rdy}, 32'd1);
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        chk("prio_still_idle", {31'd0, rdy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
